// File: rtl/fetch_pc_unit.sv
// Program-counter / fetch-address generator feeding the fetch unit.
// Advances one instruction per accepted fetch, parks on an L1I miss until
// the matching cacheline arrives, replays the missed address, and applies
// branch/exception redirects with a one-cycle pipeline flush pulse.
module fetch_pc_unit #(
    parameter int unsigned             addressSize      = 64,
    parameter int unsigned             instructionSize  = 32,
    parameter int unsigned             iCacheOffsetSize = 5,
    parameter logic [addressSize-1:0]  resetVector      = '0,
    parameter int unsigned             missCountWidth   = 16
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      cacheMiss_i,
    input  logic [addressSize-1:0]    missAddress_i,
    input  logic                      blockValid_i,
    input  logic [addressSize-1:0]    blockAddress_i,
    input  logic                      stall_i,
    input  logic                      redirect_i,
    input  logic [addressSize-1:0]    redirectAddress_i,
    output logic [addressSize-1:0]    PC_o,
    output logic                      fetchEnable_o,
    output logic                      flushPipeline_o,
    output logic [1:0]                state_o,
    output logic [missCountWidth-1:0] missCount_o
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MISS_WAIT = 2'd1,
        REPLAY    = 2'd2,
        FLUSH     = 2'd3
    } state_e;

    // Byte distance between consecutive instructions.
    localparam logic [addressSize-1:0] STEP_INC = addressSize'(instructionSize / 8);
    // Clears the sub-instruction bits of a redirect target.
    localparam logic [addressSize-1:0] ALIGN_MASK = ~(STEP_INC - addressSize'(1));
    // Keeps only the cacheline-index bits when matching a refill.
    localparam logic [addressSize-1:0] LINE_MASK =
        ~((addressSize'(1) << iCacheOffsetSize) - addressSize'(1));

    state_e                    state_q, state_d;
    logic [addressSize-1:0]    pc_q, pc_d;
    logic [addressSize-1:0]    replay_pc_q, replay_pc_d;
    logic                      fetch_en_q, fetch_en_d;
    logic                      flush_q, flush_d;
    logic [missCountWidth-1:0] miss_count_q, miss_count_d;
    logic                      block_match;

    // Delivered line is the one the parked miss is waiting for.
    assign block_match = blockValid_i &&
                         (((blockAddress_i ^ replay_pc_q) & LINE_MASK) == '0);

    // Next-state and next-output selection; redirect overrides every state.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        replay_pc_d  = replay_pc_q;
        fetch_en_d   = fetch_en_q;
        flush_d      = 1'b0;
        miss_count_d = miss_count_q;

        if (redirect_i) begin
            state_d    = FLUSH;
            pc_d       = redirectAddress_i & ALIGN_MASK;
            fetch_en_d = 1'b0;
            flush_d    = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (cacheMiss_i) begin
                        state_d     = MISS_WAIT;
                        replay_pc_d = missAddress_i;
                        pc_d        = missAddress_i;
                        fetch_en_d  = 1'b0;
                        if (miss_count_q != '1) begin
                            miss_count_d = miss_count_q + missCountWidth'(1);
                        end
                    end else if (stall_i) begin
                        fetch_en_d = 1'b0;
                    end else begin
                        // Only step past an address that was actually fetched.
                        if (fetch_en_q) begin
                            pc_d = pc_q + STEP_INC;
                        end
                        fetch_en_d = 1'b1;
                    end
                end
                MISS_WAIT: begin
                    fetch_en_d = 1'b0;
                    if (block_match) begin
                        state_d = REPLAY;
                    end
                end
                REPLAY: begin
                    // One idle cycle lets the refill write land before refetch.
                    state_d    = RUN;
                    pc_d       = replay_pc_q;
                    fetch_en_d = !stall_i;
                end
                FLUSH: begin
                    state_d    = RUN;
                    fetch_en_d = !stall_i;
                end
                default: begin
                    state_d    = RUN;
                    fetch_en_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset discards any pending replay.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= RUN;
            pc_q         <= resetVector;
            replay_pc_q  <= resetVector;
            fetch_en_q   <= 1'b0;
            flush_q      <= 1'b0;
            miss_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q      <= state_d;
            pc_q         <= pc_d;
            replay_pc_q  <= replay_pc_d;
            fetch_en_q   <= fetch_en_d;
            flush_q      <= flush_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign PC_o            = pc_q;
    assign fetchEnable_o   = fetch_en_q;
    assign flushPipeline_o = flush_q;
    assign state_o         = state_q;
    assign missCount_o     = miss_count_q;

endmodule
